// File: rtl/adder_reduce_ctrl_if.sv
// adder_reduce_ctrl_if
// Groups the operand stream, the adder-facing pass-through, the total stream
// and the error flag of adder_reduce_ctrl into one bundle.
//   in_valid/in_ready/in_data    : operand beat stream (lane k at [k*bits +: bits])
//   add_valid/add_i              : drive the external adder's valid and inputs
//   add_o/add_valid_out          : adder result and its valid
//   out_valid/out_ready/out_sum  : one total per job
//   err                          : sticky protocol error
// The slave modport is the controller's view; the master modport is the
// environment (producer, adder and consumer) view.
interface adder_reduce_ctrl_if #(
    parameter int bits  = 8,
    parameter int lanes = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [lanes*bits-1:0]   in_data;
    logic                    add_valid;
    logic [lanes*bits-1:0]   add_i;
    logic [bits-1:0]         add_o;
    logic                    add_valid_out;
    logic                    out_valid;
    logic                    out_ready;
    logic [bits-1:0]         out_sum;
    logic                    err;

    modport slave (
        input  in_valid, in_data, add_o, add_valid_out, out_ready,
        output in_ready, add_valid, add_i, out_valid, out_sum, err
    );

    modport master (
        output in_valid, in_data, add_o, add_valid_out, out_ready,
        input  in_ready, add_valid, add_i, out_valid, out_sum, err
    );
endinterface

// File: rtl/adder_reduce_ctrl.sv
// adder_reduce_ctrl
// Reduces a job of `num` operands, delivered as `num/lanes` beats, through a
// shared `lanes`-input pipelined adder. Beats pass straight through to the
// adder; its partial sums are accumulated (mod 2^bits) and the total is
// presented once per job.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (also resets the attached adder)
//   bus   : adder_reduce_ctrl_if.slave, see the interface for signal roles
module adder_reduce_ctrl #(
    parameter int bits  = 8,
    parameter int num   = 32,
    parameter int lanes = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_reduce_ctrl_if.slave   bus
);
    localparam int beats = num / lanes;
    localparam int cw    = $clog2(beats + 1);

    localparam logic [cw-1:0] beats_c = cw'(beats);
    localparam logic [cw-1:0] one_c   = cw'(1);
    localparam logic [cw-1:0] zero_c  = cw'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [cw-1:0]   beat_cnt_q, beat_cnt_d;
    logic [cw-1:0]   pend_q, pend_d;
    logic [bits-1:0] acc_q, acc_d;
    logic            err_q, err_d;

    logic            in_ready_s;
    logic            accept_s;
    logic            result_s;
    logic            spurious_s;

    // in_ready is masked by rst_n so no beat can be taken while reset is held.
    assign in_ready_s = rst_n & ((state_q == IDLE) | (state_q == FEED));
    assign accept_s   = bus.in_valid & in_ready_s;
    // A result only counts when one is actually outstanding; otherwise it
    // is a protocol error and its data is dropped.
    assign result_s   = bus.add_valid_out & (pend_q != zero_c);
    assign spurious_s = bus.add_valid_out & (pend_q == zero_c);

    assign bus.in_ready  = in_ready_s;
    assign bus.add_valid = accept_s;
    assign bus.add_i     = bus.in_data;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = acc_q;
    assign bus.err       = err_q;

    // Next-state, counter, accumulator and error logic.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        pend_d     = pend_q;
        acc_d      = acc_q;
        err_d      = err_q | spurious_s;

        if (accept_s) begin
            beat_cnt_d = beat_cnt_q + one_c;
        end else begin
            beat_cnt_d = beat_cnt_q;
        end

        case ({accept_s, result_s})
            2'b10:   pend_d = pend_q + one_c;
            2'b01:   pend_d = pend_q - one_c;
            default: pend_d = pend_q;
        endcase

        if (result_s) begin
            acc_d = acc_q + bus.add_o;
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = (beats_c == one_c) ? DRAIN : FEED;
                end else begin
                    state_d = IDLE;
                end
            end
            FEED: begin
                // Compare against the pre-increment count: this beat is the last.
                if (accept_s && (beat_cnt_q == (beats_c - one_c))) begin
                    state_d = DRAIN;
                end else begin
                    state_d = FEED;
                end
            end
            DRAIN: begin
                if (((pend_q == one_c) && bus.add_valid_out) || (pend_q == zero_c)) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d    = IDLE;
                    acc_d      = '0;
                    beat_cnt_d = '0;
                    pend_d     = '0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d    = IDLE;
                acc_d      = '0;
                beat_cnt_d = '0;
                pend_d     = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            pend_q     <= '0;
            acc_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            pend_q     <= pend_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_adder_reduce_ctrl.sv
// Bench for adder_reduce_ctrl: a 4-lane instance and a single-beat 32-lane
// instance, each with a 2-stage adder model summing its lanes mod 256.
module tb_adder_reduce_ctrl;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    adder_reduce_ctrl_if #(.bits(8), .lanes(4))  ifa ();
    adder_reduce_ctrl_if #(.bits(8), .lanes(32)) ifb ();

    adder_reduce_ctrl #(.bits(8), .num(32), .lanes(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    adder_reduce_ctrl #(.bits(8), .num(32), .lanes(32)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] lane_sum(input logic [255:0] d, input int n);
        logic [7:0] s;
        s = 8'd0;
        for (int k = 0; k < 32; k++) begin
            if (k < n) s = s + d[k*8 +: 8];
        end
        return s;
    endfunction

    // Adder model A (L=2) with a spurious-result injection port.
    logic [7:0] a_s1, a_s2;
    logic       a_v1, a_v2;
    logic       spur_a;
    logic [7:0] spur_d;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_v1 <= 1'b0; a_v2 <= 1'b0; a_s1 <= 8'd0; a_s2 <= 8'd0;
        end else begin
            a_v1 <= ifa.add_valid;
            a_s1 <= lane_sum(256'(ifa.add_i), 4);
            a_v2 <= a_v1;
            a_s2 <= a_s1;
        end
    end
    assign ifa.add_valid_out = a_v2 | spur_a;
    assign ifa.add_o         = spur_a ? spur_d : a_s2;

    // Adder model B (L=2), 32 lanes.
    logic [7:0] b_s1, b_s2;
    logic       b_v1, b_v2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_v1 <= 1'b0; b_v2 <= 1'b0; b_s1 <= 8'd0; b_s2 <= 8'd0;
        end else begin
            b_v1 <= ifb.add_valid;
            b_s1 <= lane_sum(ifb.add_i, 32);
            b_v2 <= b_v1;
            b_s2 <= b_s1;
        end
    end
    assign ifb.add_valid_out = b_v2;
    assign ifb.add_o         = b_s2;

    // Job operands and per-job observations.
    logic [7:0] ops [32];
    logic [7:0] j_sum;
    int         j_t_last, j_t_out, j_av_cnt, j_av_runmax;
    bit         j_stable, j_post_ok, j_timeout;

    function automatic logic [7:0] expected_total();
        int s;
        s = 0;
        for (int k = 0; k < 32; k++) s += int'(ops[k]);
        return 8'(s % 256);
    endfunction

    // Drives one job on instance A and records what was observed.
    task automatic run_job(input int gap_pct, input int stall);
        int idx, guard, stalled, run;
        bit seen, done;
        idx = 0; guard = 0; run = 0;
        j_timeout = 1'b0; j_t_last = -1; j_t_out = -1; j_av_cnt = 0; j_av_runmax = 0;
        j_stable = 1'b1; j_post_ok = 1'b0; j_sum = 8'd0;
        ifa.out_ready = (stall == 0);
        while (idx < 8 && guard < 400) begin
            @(negedge clk);
            guard++;
            ifa.in_valid = ($urandom_range(0, 99) >= gap_pct);
            ifa.in_data  = {ops[idx*4+3], ops[idx*4+2], ops[idx*4+1], ops[idx*4]};
            #1;
            if (ifa.add_valid) begin
                j_av_cnt++; run++;
                if (run > j_av_runmax) j_av_runmax = run;
            end else begin
                run = 0;
            end
            if (ifa.in_valid && ifa.in_ready) begin
                j_t_last = cyc;
                idx++;
            end
        end
        if (idx < 8) j_timeout = 1'b1;
        seen = 1'b0; done = 1'b0; stalled = 0; guard = 0;
        while (!done && !j_timeout && guard < 100) begin
            @(negedge clk);
            guard++;
            ifa.in_valid = 1'b0;
            #1;
            if (ifa.add_valid) j_av_cnt++;
            if (ifa.out_valid) begin
                if (!seen) begin
                    seen = 1'b1; j_t_out = cyc; j_sum = ifa.out_sum;
                end else if (ifa.out_sum !== j_sum) begin
                    j_stable = 1'b0;
                end
                if (ifa.in_ready !== 1'b0) j_stable = 1'b0;
                if (stalled >= stall) begin
                    ifa.out_ready = 1'b1;
                    done = 1'b1;
                end else begin
                    stalled++;
                end
            end else if (seen) begin
                j_stable = 1'b0;
            end
        end
        if (!done) j_timeout = 1'b1;
        @(negedge clk);
        #1;
        j_post_ok = (ifa.out_valid === 1'b0) && (ifa.in_ready === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.in_valid = 1'b1; ifb.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({ifa.in_ready, ifa.add_valid, ifa.out_valid, ifa.out_sum, ifa.err} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_a: got rdy=%b av=%b ov=%b sum=%h err=%b, want all 0",
                     ifa.in_ready, ifa.add_valid, ifa.out_valid, ifa.out_sum, ifa.err);
        end
        n_tests++;
        if ({ifb.in_ready, ifb.add_valid, ifb.out_valid, ifb.out_sum, ifb.err} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_b: got rdy=%b av=%b ov=%b sum=%h err=%b, want all 0",
                     ifb.in_ready, ifb.add_valid, ifb.out_valid, ifb.out_sum, ifb.err);
        end
        ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0 || ifa.err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got rdy=%b ov=%b err=%b, want 1 0 0",
                     ifa.in_ready, ifa.out_valid, ifa.err);
        end
    endtask

    task automatic check_job(input string name, input logic [7:0] exp, input bit chk_err, input logic exp_err);
        n_tests++;
        if (j_timeout) begin
            n_fail++;
            $display("FAIL %s_timeout: job did not complete, want completion", name);
        end
        n_tests++;
        if (j_sum !== exp) begin
            n_fail++;
            $display("FAIL %s_sum: got %h, want %h", name, j_sum, exp);
        end
        n_tests++;
        if (j_t_out !== j_t_last + 3) begin
            n_fail++;
            $display("FAIL %s_latency: out_valid at %0d, want %0d", name, j_t_out, j_t_last + 3);
        end
        n_tests++;
        if (j_av_cnt !== 8) begin
            n_fail++;
            $display("FAIL %s_add_valid_count: got %0d, want 8", name, j_av_cnt);
        end
        n_tests++;
        if (!j_stable || !j_post_ok) begin
            n_fail++;
            $display("FAIL %s_handshake: stable=%0d post=%0d, want 1 1", name, j_stable, j_post_ok);
        end
        if (chk_err) begin
            n_tests++;
            if (ifa.err !== exp_err) begin
                n_fail++;
                $display("FAIL %s_err: got %b, want %b", name, ifa.err, exp_err);
            end
        end
    endtask

    task automatic test_ones_back_to_back();
        for (int k = 0; k < 32; k++) ops[k] = 8'd1;
        run_job(0, 0);
        check_job("ones", expected_total(), 1'b1, 1'b0);
        n_tests++;
        if (j_av_runmax !== 8) begin
            n_fail++;
            $display("FAIL ones_add_valid_run: got %0d, want 8", j_av_runmax);
        end
    endtask

    task automatic test_all_ff();
        for (int k = 0; k < 32; k++) ops[k] = 8'hFF;
        run_job(0, 0);
        check_job("allff", 8'hE0, 1'b0, 1'b0);
    endtask

    task automatic test_ramp_gaps_stall();
        for (int k = 0; k < 32; k++) ops[k] = 8'(k);
        run_job(40, 5);
        check_job("ramp_stall", 8'hF0, 1'b0, 1'b0);
        run_job(0, 0);
        check_job("ramp_again", expected_total(), 1'b0, 1'b0);
    endtask

    task automatic test_spurious();
        @(negedge clk);
        spur_d = 8'h55; spur_a = 1'b1;
        @(negedge clk);
        spur_a = 1'b0;
        #1;
        n_tests++;
        if (ifa.err !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_err_set: got %b, want 1", ifa.err);
        end
        for (int k = 0; k < 32; k++) ops[k] = 8'd1;
        run_job(20, 1);
        check_job("after_spurious", 8'h20, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_job();
        bit saw_ov;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ifa.in_valid = 1'b1;
            ifa.in_data  = {4{8'd9}};
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ifa.in_ready !== 1'b0 || ifa.add_valid !== 1'b0 || ifa.err !== 1'b0 || ifa.out_sum !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got rdy=%b av=%b err=%b sum=%h, want 0 0 0 00",
                     ifa.in_ready, ifa.add_valid, ifa.err, ifa.out_sum);
        end
        ifa.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_ov = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            if (ifa.out_valid !== 1'b0 || ifa.out_sum !== 8'd0 || ifa.err !== 1'b0) saw_ov = 1'b1;
        end
        n_tests++;
        if (saw_ov) begin
            n_fail++;
            $display("FAIL midreset_no_output: got stray output after reset, want none");
        end
        for (int k = 0; k < 32; k++) ops[k] = 8'(k);
        run_job(10, 0);
        check_job("after_midreset", 8'hF0, 1'b1, 1'b0);
    endtask

    task automatic test_single_beat();
        int t_last, t_out, guard;
        logic [7:0] sum;
        ifb.out_ready = 1'b1;
        @(negedge clk);
        ifb.in_valid = 1'b1;
        ifb.in_data  = {32{8'd2}};
        #1;
        t_last = cyc;
        n_tests++;
        if (ifb.add_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept: add_valid=%b, want 1", ifb.add_valid);
        end
        @(negedge clk);
        ifb.in_valid = 1'b0;
        #1;
        n_tests++;
        if (ifb.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_direct_drain: in_ready=%b, want 0", ifb.in_ready);
        end
        t_out = -1; sum = 8'd0; guard = 0;
        while (t_out < 0 && guard < 50) begin
            if (ifb.out_valid) begin
                t_out = cyc; sum = ifb.out_sum;
            end else begin
                @(negedge clk);
                #1;
                guard++;
            end
        end
        n_tests++;
        if (sum !== 8'h40 || t_out !== t_last + 3) begin
            n_fail++;
            $display("FAIL single_total: sum=%h at %0d, want 40 at %0d", sum, t_out, t_last + 3);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        spur_a = 1'b0; spur_d = 8'd0;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;
        test_reset();
        test_ones_back_to_back();
        test_all_ff();
        test_ramp_gaps_stall();
        test_spurious();
        test_reset_mid_job();
        test_single_beat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
